// File: rtl/inst_sequencer.sv
// inst_sequencer: autonomous generator of the 34-bit core instruction word,
// sequencing weight/activation fills, kernel load, execute per kij, then the OFIFO drain.
module inst_sequencer #(
  parameter int          COL      = 8,
  parameter int          ROW      = 8,
  parameter int          NUM_KIJ  = 9,
  parameter int          LEN_NIJ  = 36,
  parameter int          LOAD_CYC = 72,
  parameter int          GAP_CYC  = 11,
  parameter int          EXEC_CYC = (ROW + COL) * LEN_NIJ + 10,
  parameter int          NUM_OUT  = 17,
  parameter logic [10:0] W_BASE   = 11'h400
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        ofifo_valid,
  output logic [33:0] inst,
  output logic        busy,
  output logic        done,
  output logic        out_strobe,
  output logic [3:0]  kij_idx
);
  localparam logic [33:0] IDLE_W = 34'h1800C0000;
  typedef enum logic [3:0] {
    S_IDLE, S_WFILL, S_WLOAD, S_GAP, S_AFILL, S_EXEC, S_WAIT, S_HOLD, S_DONE
  } state_t;
  state_t      st_q, st_d;
  logic [31:0] c_q, c_d, n_q, n_d;
  logic [3:0]  kij_q, kij_d;
  logic [33:0] inst_q, inst_d;
  logic        done_q, done_d, strobe_q, strobe_d;
  logic        cen_x, l0_wr, l0_rd, ex, ld, rd;
  logic [10:0] a_x, w_addr;
  assign w_addr = W_BASE + 11'(kij_q * COL);
  always_comb begin
    st_d = st_q;
    c_d = c_q + 32'd1;
    n_d = n_q;
    kij_d = kij_q;
    cen_x = 1'b1;
    a_x = '0;
    {l0_wr, l0_rd, ex, ld, rd, done_d, strobe_d} = '0;
    case (st_q)
      S_IDLE: begin
        c_d = '0;
        if (start) begin
          st_d = S_WFILL;
          kij_d = '0;
          n_d = '0;
        end
      end
      S_WFILL: begin
        cen_x = c_q > COL;
        a_x = c_q > COL + 1 ? '0 : w_addr + 11'(c_q < COL ? c_q : COL - 1);
        l0_wr = c_q >= 1 && c_q <= COL + 1;
        if (c_q == COL + 2) begin
          st_d = S_WLOAD;
          c_d = '0;
        end
      end
      S_WLOAD: begin
        ld = c_q < LOAD_CYC;
        l0_rd = ld;
        if (c_q == LOAD_CYC) begin
          st_d = S_GAP;
          c_d = '0;
        end
      end
      S_GAP: if (c_q == GAP_CYC - 1) begin
        st_d = S_AFILL;
        c_d = '0;
      end
      S_AFILL: begin
        cen_x = c_q >= LEN_NIJ;
        a_x = c_q > LEN_NIJ ? '0 : 11'(c_q < LEN_NIJ ? c_q : LEN_NIJ - 1);
        l0_wr = c_q >= 1 && c_q <= LEN_NIJ;
        if (c_q == LEN_NIJ + 1) begin
          st_d = S_EXEC;
          c_d = '0;
        end
      end
      S_EXEC: begin
        ex = c_q < EXEC_CYC;
        l0_rd = ex;
        if (c_q == EXEC_CYC) begin
          c_d = '0;
          st_d = kij_q == 4'(NUM_KIJ - 1) ? S_WAIT : S_WFILL;
          kij_d = kij_q == 4'(NUM_KIJ - 1) ? kij_q : kij_q + 4'd1;
        end
      end
      // The wait cycle that sees ofifo_valid issues the read itself, so back-to-back reads are 4 cycles apart
      S_WAIT: begin
        c_d = '0;
        rd = ofifo_valid;
        if (ofifo_valid) st_d = S_HOLD;
      end
      S_HOLD: if (c_q == 32'd2) begin
        c_d = '0;
        strobe_d = 1'b1;
        n_d = n_q + 32'd1;
        st_d = n_q + 32'd1 < NUM_OUT ? S_WAIT : S_DONE;
      end
      S_DONE: begin
        done_d = 1'b1;
        c_d = '0;
        st_d = S_IDLE;
      end
      default: st_d = S_IDLE;
    endcase
    inst_d = {rd, 2'b11, 11'd0, cen_x, 1'b1, a_x, rd, 2'b00, l0_rd, l0_wr, ex, ld};
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st_q <= S_IDLE;
      c_q <= '0;
      n_q <= '0;
      kij_q <= '0;
      inst_q <= IDLE_W;
      done_q <= 1'b0;
      strobe_q <= 1'b0;
    end else begin
      st_q <= st_d;
      c_q <= c_d;
      n_q <= n_d;
      kij_q <= kij_d;
      inst_q <= inst_d;
      done_q <= done_d;
      strobe_q <= strobe_d;
    end
  end
  assign inst = inst_q;
  assign busy = st_q != S_IDLE;
  assign done = done_q;
  assign out_strobe = strobe_q;
  assign kij_idx = kij_q;
endmodule

// File: tb/tb_inst_sequencer.sv
// tb_inst_sequencer: scoreboard of the expected instruction stream built from the bit map and phase lengths,
// popped and compared every cycle while a run is monitored.
module tb_inst_sequencer;
  localparam logic [33:0] IDLE_W = 34'h1800C0000;
  localparam int ACC0 = 6480;
  localparam int NEVER = 1 << 30;
  logic clk = 1'b0, reset = 1'b0, start = 1'b0, ofifo_valid = 1'b0;
  logic [33:0] inst;
  logic busy, done, out_strobe;
  logic [3:0] kij_idx;
  int vectors = 0, miscompares = 0;
  typedef struct {
    logic [33:0] w;
    logic [2:0]  bds;
    logic        kc;
    logic [3:0]  k;
  } exp_t;
  exp_t exp_q[$];
  exp_t e;
  bit mon_en = 1'b0;
  logic [33:0] log_w [0:7999];
  int widx, ld_cnt, ex_cnt, rd_cnt, st_cnt, dn_cnt;

  inst_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .ofifo_valid(ofifo_valid),
    .inst(inst), .busy(busy), .done(done), .out_strobe(out_strobe), .kij_idx(kij_idx)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (mon_en) begin
      if (widx < 8000) log_w[widx] = inst;
      widx++;
      if (inst[0]) ld_cnt++;
      if (inst[1]) ex_cnt++;
      if (inst[6]) rd_cnt++;
      if (out_strobe) st_cnt++;
      if (done) dn_cnt++;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        vectors++;
        if ({inst, busy, done, out_strobe} !== {e.w, e.bds}) begin
          miscompares++;
          $display("FAIL word[%0d] inst=%h busy=%b done=%b strobe=%b expected inst=%h busy=%b done=%b strobe=%b",
                   widx - 1, inst, busy, done, out_strobe, e.w, e.bds[2], e.bds[1], e.bds[0]);
        end
        if (e.kc) begin
          vectors++;
          if (kij_idx !== e.k) begin
            miscompares++;
            $display("FAIL kij[%0d] got %0d expected %0d", widx - 1, kij_idx, e.k);
          end
        end
      end
    end
  end

  // flags = {ofifo_rd/acc, l0_rd, l0_wr, execute, load}
  function automatic logic [33:0] wd(input logic cen, input logic [10:0] ax, input logic [4:0] f);
    return {f[4], 2'b11, 11'd0, cen, 1'b1, ax, f[4], 2'b00, f[3], f[2], f[1], f[0]};
  endfunction

  task automatic push(input logic [33:0] w, input logic [2:0] bds, input logic kc, input logic [3:0] k);
    exp_t x;
    x.w = w;
    x.bds = bds;
    x.kc = kc;
    x.k = k;
    exp_q.push_back(x);
  endtask

  task automatic gen_run(input int wait0, input int extra);
    for (int k = 0; k < 9; k++) begin
      logic [10:0] base;
      base = 11'h400 + 11'(k * 8);
      push(wd(1'b0, base, 5'b00000), 3'b100, 1'b1, 4'(k));
      for (int c = 1; c <= 8; c++) push(wd(1'b0, base + 11'(c < 8 ? c : 7), 5'b00100), 3'b100, 1'b1, 4'(k));
      push(wd(1'b1, base + 11'd7, 5'b00100), 3'b100, 1'b1, 4'(k));
      push(IDLE_W, 3'b100, 1'b1, 4'(k));
      for (int c = 0; c < 72; c++) push(wd(1'b1, 11'd0, 5'b01001), 3'b100, 1'b1, 4'(k));
      for (int c = 0; c < 12; c++) push(IDLE_W, 3'b100, 1'b1, 4'(k));
      push(wd(1'b0, 11'd0, 5'b00000), 3'b100, 1'b1, 4'(k));
      for (int c = 1; c <= 36; c++) push(wd(c == 36, 11'(c < 36 ? c : 35), 5'b00100), 3'b100, 1'b1, 4'(k));
      push(IDLE_W, 3'b100, 1'b1, 4'(k));
      for (int c = 0; c < 586; c++) push(wd(1'b1, 11'd0, 5'b01010), 3'b100, 1'b1, 4'(k));
      push(IDLE_W, 3'b100, k < 8, 4'(k + 1));
    end
    for (int i = 0; i < wait0; i++) push(IDLE_W, 3'b100, 1'b0, 4'd0);
    for (int i = 0; i < 17; i++) begin
      push(wd(1'b1, 11'd0, 5'b10000), 3'b100, 1'b0, 4'd0);
      push(IDLE_W, 3'b100, 1'b0, 4'd0);
      push(IDLE_W, 3'b100, 1'b0, 4'd0);
      push(IDLE_W, 3'b101, 1'b0, 4'd0);
    end
    push(IDLE_W, 3'b010, 1'b0, 4'd0);
    for (int i = 0; i < extra; i++) push(IDLE_W, 3'b000, 1'b0, 4'd0);
  endtask

  // cycle j is the state-cycle whose word appears at the edge ending it
  task automatic drive(input int ncyc, input int acc_at, input int s1, input int s2);
    widx = 0;
    ld_cnt = 0;
    ex_cnt = 0;
    rd_cnt = 0;
    st_cnt = 0;
    dn_cnt = 0;
    @(posedge clk);
    #1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int j = 0; j < ncyc; j++) begin
      ofifo_valid = j >= acc_at;
      start = j == s1 || j == s2;
      @(posedge clk);
      mon_en = 1'b1;
      #1;
    end
    start = 1'b0;
    ofifo_valid = 1'b0;
    @(negedge clk);
    #1;
    mon_en = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      start = i[0];
      @(negedge clk);
      vectors++;
      if ({inst, busy, done, out_strobe} !== {IDLE_W, 3'b000}) begin
        miscompares++;
        $display("FAIL reset_idle inst=%h busy=%b done=%b strobe=%b expected %h/0/0/0", inst, busy, done, out_strobe, IDLE_W);
      end
      vectors++;
      if (kij_idx !== 4'd0) begin
        miscompares++;
        $display("FAIL reset_kij got %0d expected 0", kij_idx);
      end
    end
    start = 1'b0;
    @(posedge clk);
    #2;
    reset = 1'b1;
  endtask

  task automatic test_drain();
    gen_run(50, 3);
    drive(6599 + 3, ACC0 + 50, -1, -1);
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain_leftover got %0d expected 0 words", exp_q.size());
      exp_q.delete();
    end
    vectors++;
    if (rd_cnt != 17 || st_cnt != 17) begin
      miscompares++;
      $display("FAIL drain_counts rd=%0d strobe=%0d expected 17/17", rd_cnt, st_cnt);
    end
    vectors++;
    if (dn_cnt != 1 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL drain_done done_pulses=%0d busy=%b expected 1/0", dn_cnt, busy);
    end
    for (int i = ACC0; i < ACC0 + 50; i++) begin
      vectors++;
      if (log_w[i][6] !== 1'b0) begin
        miscompares++;
        $display("FAIL drain_hold word[%0d] ofifo_rd=%b expected 0", i, log_w[i][6]);
      end
    end
  endtask

  task automatic test_wfill_kij2();
    logic [10:0] ea [0:8];
    ea = '{11'h410, 11'h411, 11'h412, 11'h413, 11'h414, 11'h415, 11'h416, 11'h417, 11'h417};
    for (int c = 0; c < 9; c++) begin
      vectors++;
      if (log_w[1440 + c][17:7] !== ea[c]) begin
        miscompares++;
        $display("FAIL wfill_addr c=%0d got %h expected %h", c, log_w[1440 + c][17:7], ea[c]);
      end
    end
    for (int c = 0; c < 11; c++) begin
      vectors++;
      if ({log_w[1440 + c][2], log_w[1440 + c][19]} !== {c >= 1 && c <= 9, c >= 9}) begin
        miscompares++;
        $display("FAIL wfill_ctl c=%0d l0_wr=%b cen=%b expected %b/%b", c, log_w[1440 + c][2], log_w[1440 + c][19], c >= 1 && c <= 9, c >= 9);
      end
    end
  endtask

  task automatic test_phase_counts();
    vectors++;
    if (ld_cnt != 648 || ex_cnt != 5274) begin
      miscompares++;
      $display("FAIL phase_counts load=%0d execute=%0d expected 648/5274", ld_cnt, ex_cnt);
    end
    vectors++;
    if ({log_w[ACC0 - 2][1], log_w[ACC0 - 1], log_w[ACC0]} !== {1'b1, IDLE_W, IDLE_W}) begin
      miscompares++;
      $display("FAIL acc_wait_start exec=%b words=%h,%h expected 1,%h,%h", log_w[ACC0 - 2][1], log_w[ACC0 - 1], log_w[ACC0], IDLE_W, IDLE_W);
    end
    vectors++;
    if (log_w[0][17:7] !== 11'h400) begin
      miscompares++;
      $display("FAIL first_wfill_addr got %h expected 400", log_w[0][17:7]);
    end
  endtask

  task automatic test_abort();
    gen_run(0, 0);
    drive(4 * 720 + 133 + 100, NEVER, -1, -1);
    exp_q.delete();
    vectors++;
    if ({kij_idx, inst[1]} !== {4'd4, 1'b1}) begin
      miscompares++;
      $display("FAIL abort_pre kij=%0d execute=%b expected 4/1", kij_idx, inst[1]);
    end
    reset = 1'b0;
    #1;
    vectors++;
    if ({inst, busy, kij_idx} !== {IDLE_W, 1'b0, 4'd0}) begin
      miscompares++;
      $display("FAIL abort_async inst=%h busy=%b kij=%0d expected %h/0/0", inst, busy, kij_idx, IDLE_W);
    end
    @(posedge clk);
    #3;
    reset = 1'b1;
    gen_run(0, 0);
    drive(11, NEVER, -1, -1);
    exp_q.delete();
    vectors++;
    if (log_w[0][17:7] !== 11'h400) begin
      miscompares++;
      $display("FAIL abort_restart_addr got %h expected 400", log_w[0][17:7]);
    end
    reset = 1'b0;
    @(posedge clk);
    #3;
    reset = 1'b1;
  endtask

  task automatic test_start_ignored();
    gen_run(0, 4);
    drive(6549 + 4, 0, 820, 6548);
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL start_ignored_leftover got %0d expected 0 words", exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    test_reset();
    test_drain();
    test_wfill_kij2();
    test_phase_counts();
    test_abort();
    test_start_ignored();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
